// File: rtl/ecc_scrub_scheduler.sv
// ecc_scrub_scheduler
// Arbitrates one 72-bit ECC memory read port between host reads and a background scrubber.
// Each returned word is checked: check byte [71:64] must equal {7'b0, ^data[63:0]}.
// Host reads win arbitration, but after MAX_DEFER host grants with a scrub pending the
// scrub is forced through. Errors from either source are counted (saturating) and the
// first failing address/source is held until err_clear.
//
// Ports:
//   sys_clk, sys_rst          clock, asynchronous active-high reset
//   host_req/host_addr        host read request; host_ready accepts it (combinational)
//   host_rvalid/rdata/err     registered read response, 2 cycles after acceptance
//   mem_rd_en/mem_addr        memory read strobe/address (address is 0 when idle)
//   mem_rdata                 memory data, valid 1 cycle after mem_rd_en
//   scrub_en                  enables background scrubbing
//   scrub_pass_done           pulse after the scrub read of the last address
//   err_count/valid/addr/src  error log; err_clear resets it
module ecc_scrub_scheduler #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned SCRUB_INTERVAL = 1024,
  parameter int unsigned MAX_DEFER      = 8,
  parameter int unsigned ERR_CNT_WIDTH  = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     host_req,
  input  logic [ADDR_WIDTH-1:0]    host_addr,
  output logic                     host_ready,
  output logic                     host_rvalid,
  output logic [63:0]              host_rdata,
  output logic                     host_err,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [71:0]              mem_rdata,
  input  logic                     scrub_en,
  output logic                     scrub_pass_done,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     err_valid,
  output logic [ADDR_WIDTH-1:0]    err_addr,
  output logic                     err_src,
  input  logic                     err_clear
);

  localparam int unsigned IntW   = $clog2(SCRUB_INTERVAL);
  localparam int unsigned DeferW = $clog2(MAX_DEFER + 1);
  localparam logic [IntW-1:0]   IntReload = IntW'(SCRUB_INTERVAL - 1);
  localparam logic [DeferW-1:0] DeferMax  = DeferW'(MAX_DEFER);

  typedef enum logic [1:0] {StIdle, StHostRd, StScrubRd} state_e;

  state_e state_q, state_d;

  logic [IntW-1:0]          int_cnt_q, int_cnt_d;
  logic                     pending_q, pending_d;
  logic [DeferW-1:0]        defer_q, defer_d;
  logic [ADDR_WIDTH-1:0]    ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]    rd_addr_q, rd_addr_d;
  logic                     pass_done_q, pass_done_d;
  logic                     rvalid_q, rvalid_d;
  logic [63:0]              rdata_q, rdata_d;
  logic                     herr_q, herr_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     evalid_q, evalid_d;
  logic [ADDR_WIDTH-1:0]    eaddr_q, eaddr_d;
  logic                     esrc_q, esrc_d;

  logic scrub_req, force_scrub, host_grant, scrub_issue, chk_fail;

  // A pending scrub only counts while scrubbing is enabled, so dropping scrub_en
  // never lets a stale request slip out in the same cycle.
  assign scrub_req   = pending_q && scrub_en;
  assign force_scrub = scrub_req && (defer_q == DeferMax);
  assign chk_fail    = (state_q != StIdle) &&
                       (mem_rdata[71:64] != {7'b0, ^mem_rdata[63:0]});

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (host_grant)       state_d = StHostRd;
        else if (scrub_issue) state_d = StScrubRd;
      end
      StHostRd:  state_d = StIdle;
      StScrubRd: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output / arbitration logic
  always_comb begin
    host_ready  = (state_q == StIdle) && !force_scrub;
    host_grant  = host_ready && host_req;
    scrub_issue = (state_q == StIdle) && !host_grant && scrub_req;
    mem_rd_en   = host_grant || scrub_issue;
    mem_addr    = '0;
    if (host_grant)       mem_addr = host_addr;
    else if (scrub_issue) mem_addr = ptr_q;
  end

  // Datapath next-state
  always_comb begin
    int_cnt_d   = int_cnt_q;
    pending_d   = pending_q;
    defer_d     = defer_q;
    ptr_d       = ptr_q;
    rd_addr_d   = mem_rd_en ? mem_addr : rd_addr_q;
    pass_done_d = (state_q == StScrubRd) && (ptr_q == '1);
    rvalid_d    = (state_q == StHostRd);
    rdata_d     = rdata_q;
    herr_d      = herr_q;
    cnt_d       = cnt_q;
    evalid_d    = evalid_q;
    eaddr_d     = eaddr_q;
    esrc_d      = esrc_q;

    if (state_q == StHostRd) begin
      rdata_d = mem_rdata[63:0];
      herr_d  = chk_fail;
    end
    if (state_q == StScrubRd) ptr_d = ptr_q + ADDR_WIDTH'(1);

    if (!scrub_en) begin
      int_cnt_d = IntReload;
      pending_d = 1'b0;
      defer_d   = '0;
    end else begin
      if (scrub_issue) begin
        pending_d = 1'b0;
        defer_d   = '0;
      end else if (host_grant && scrub_req) begin
        defer_d = defer_q + DeferW'(1);
      end
      // At zero with a request already outstanding, park at zero instead of reloading.
      if (int_cnt_q == '0) begin
        if (!pending_q) begin
          pending_d = 1'b1;
          int_cnt_d = IntReload;
        end
      end else begin
        int_cnt_d = int_cnt_q - IntW'(1);
      end
    end

    // Clear first so a failure in the same cycle lands in a fresh log.
    if (err_clear) begin
      cnt_d    = '0;
      evalid_d = 1'b0;
      eaddr_d  = '0;
      esrc_d   = 1'b0;
    end
    if (chk_fail) begin
      if (cnt_d != '1) cnt_d = cnt_d + ERR_CNT_WIDTH'(1);
      if (!evalid_d) begin
        evalid_d = 1'b1;
        eaddr_d  = rd_addr_q;
        esrc_d   = (state_q == StScrubRd);
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      int_cnt_q   <= IntReload;
      pending_q   <= 1'b0;
      defer_q     <= '0;
      ptr_q       <= '0;
      rd_addr_q   <= '0;
      pass_done_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      herr_q      <= 1'b0;
      cnt_q       <= '0;
      evalid_q    <= 1'b0;
      eaddr_q     <= '0;
      esrc_q      <= 1'b0;
    end else begin
      int_cnt_q   <= int_cnt_d;
      pending_q   <= pending_d;
      defer_q     <= defer_d;
      ptr_q       <= ptr_d;
      rd_addr_q   <= rd_addr_d;
      pass_done_q <= pass_done_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      herr_q      <= herr_d;
      cnt_q       <= cnt_d;
      evalid_q    <= evalid_d;
      eaddr_q     <= eaddr_d;
      esrc_q      <= esrc_d;
    end
  end

  assign host_rvalid     = rvalid_q;
  assign host_rdata      = rdata_q;
  assign host_err        = herr_q;
  assign scrub_pass_done = pass_done_q;
  assign err_count       = cnt_q;
  assign err_valid       = evalid_q;
  assign err_addr        = eaddr_q;
  assign err_src         = esrc_q;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Directed bench for ecc_scrub_scheduler. Error counter is narrowed to 8 bits so
// saturation is reachable in a short run; the scrub interval is 4 cycles.
module tb_ecc_scrub_scheduler;

  localparam int unsigned AW = 10;
  localparam int unsigned EW = 8;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          host_req;
  logic [AW-1:0] host_addr;
  logic          host_ready;
  logic          host_rvalid;
  logic [63:0]   host_rdata;
  logic          host_err;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [71:0]   mem_rdata;
  logic          scrub_en;
  logic          scrub_pass_done;
  logic [EW-1:0] err_count;
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic          err_src;
  logic          err_clear;

  logic [71:0] mem_word [1024];

  int total = 0;
  int bad   = 0;

  ecc_scrub_scheduler #(
    .ADDR_WIDTH    (AW),
    .SCRUB_INTERVAL(4),
    .MAX_DEFER     (8),
    .ERR_CNT_WIDTH (EW)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .host_req       (host_req),
    .host_addr      (host_addr),
    .host_ready     (host_ready),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .host_err       (host_err),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .scrub_en       (scrub_en),
    .scrub_pass_done(scrub_pass_done),
    .err_count      (err_count),
    .err_valid      (err_valid),
    .err_addr       (err_addr),
    .err_src        (err_src),
    .err_clear      (err_clear)
  );

  always #5 sys_clk = ~sys_clk;

  // One-cycle read latency memory model
  always @(posedge sys_clk) begin
    if (mem_rd_en) mem_rdata <= mem_word[mem_addr];
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the response cycle.
  task automatic host_rd(input logic [AW-1:0] a, input bit do_chk,
                         input logic [63:0] exp_data, input bit exp_err);
    host_req  = 1'b1;
    host_addr = a;
    #1;
    if (do_chk) begin
      chk("acc_ready", host_ready, 1'b1);
      chk("acc_rd_en", mem_rd_en, 1'b1);
      chk("acc_addr", mem_addr, a);
    end
    @(posedge sys_clk); #1;
    host_req  = 1'b0;
    host_addr = '0;
    if (do_chk) begin
      chk("n1_rvalid", host_rvalid, 1'b0);
      chk("n1_ready", host_ready, 1'b0);
    end
    @(posedge sys_clk); #1;
    if (do_chk) begin
      chk("n2_rvalid", host_rvalid, 1'b1);
      chk("n2_rdata", host_rdata, exp_data);
      chk("n2_err", host_err, exp_err);
    end
  endtask

  initial begin
    int grants, n_scrub, c7, pd_at, n, exp_ptr, passes, rv_seen;

    sys_rst   = 1'b1;
    host_req  = 1'b0;
    host_addr = '0;
    scrub_en  = 1'b0;
    err_clear = 1'b0;
    mem_rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      logic [63:0] d;
      d = 64'h1234_0000_0000_0000 | 64'(i);
      mem_word[i] = {7'b0, ^d, d};
    end
    mem_word[5]       = {8'h01, 64'h1};
    mem_word[10'h2A3] = {8'h01, 64'h3};
    mem_word[16]      = mem_word[16] ^ {8'h01, 64'h0};
    mem_word[7]       = mem_word[7] ^ {8'h01, 64'h0};

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst_host", {host_rvalid, host_rdata, host_err, mem_rd_en, mem_addr}, '0);
    chk("rst_err", {err_count, err_valid, err_addr, err_src, scrub_pass_done}, '0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    chk("rel_ready", host_ready, 1'b1);

    // Good host read, then two erroring host reads
    host_rd(10'd5, 1'b1, 64'h1, 1'b0);
    chk("good_cnt", err_count, 0);
    chk("good_valid", err_valid, 1'b0);
    host_rd(10'h2A3, 1'b1, 64'h3, 1'b1);
    chk("e1_cnt", err_count, 1);
    chk("e1_valid", err_valid, 1'b1);
    chk("e1_addr", err_addr, 10'h2A3);
    chk("e1_src", err_src, 1'b0);
    @(posedge sys_clk); #1;
    chk("rvalid_pulse", host_rvalid, 1'b0);
    host_rd(10'h10, 1'b1, 64'h1234_0000_0000_0010, 1'b1);
    chk("e2_cnt", err_count, 2);
    chk("e2_addr", err_addr, 10'h2A3);

    err_clear = 1'b1;
    @(posedge sys_clk); #1;
    err_clear = 1'b0;
    chk("clr_log", {err_count, err_valid, err_addr, err_src}, '0);

    // Continuous host traffic against pending scrubs
    grants = 0; n_scrub = 0;
    scrub_en  = 1'b1;
    host_req  = 1'b1;
    host_addr = 10'h100;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_rd_en && host_ready) grants++;
      if (mem_rd_en && !host_ready) begin
        if (n_scrub == 0) begin
          chk("force1_cycle", c, 20);
          chk("force1_grants", grants, 10);
          chk("force1_addr", mem_addr, 0);
        end else begin
          chk("force2_cycle", c, 38);
          chk("force2_grants", grants, 8);
          chk("force2_addr", mem_addr, 1);
        end
        grants = 0;
        n_scrub++;
      end
      if (c == 22) chk("host_resume", host_ready, 1'b1);
      if (c == 39) begin
        host_req  = 1'b0;
        host_addr = '0;
        scrub_en  = 1'b0;
      end
      @(posedge sys_clk); #1;
    end
    chk("force_count", n_scrub, 2);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("defer_errs", err_count, 0);

    host_rd(10'h10, 1'b1, 64'h1234_0000_0000_0010, 1'b1);
    chk("pre_sweep_addr", err_addr, 10'h10);

    // Full scrub sweep from ptr 2, with err_clear colliding with the addr 7 error
    c7 = -100; pd_at = -100; n = 0; exp_ptr = 2; passes = 0;
    scrub_en = 1'b1;
    for (int c = 0; c < 4096; c++) begin
      err_clear = (c == c7 + 1);
      #1;
      if (c == c7 + 2) begin
        chk("clr_hit_cnt", err_count, 1);
        chk("clr_hit_valid", err_valid, 1'b1);
        chk("clr_hit_addr", err_addr, 7);
        chk("clr_hit_src", err_src, 1'b1);
      end
      if (mem_rd_en) begin
        chk("scrub_addr", mem_addr, exp_ptr);
        chk("scrub_cycle", c, 4 * (n + 1));
        if (exp_ptr == 7) c7 = c;
        if (exp_ptr == 1023) pd_at = c + 2;
        exp_ptr = (exp_ptr + 1) % 1024;
        n++;
      end
      if (scrub_pass_done) begin
        passes++;
        chk("pass_cycle", c, pd_at);
      end
      @(posedge sys_clk); #1;
    end
    scrub_en = 1'b0;
    #1;
    chk("sweep_stop", mem_rd_en, 1'b0);
    chk("sweep_passes", passes, 1);
    chk("sweep_reads", n, 1023);
    chk("sweep_cnt", err_count, 3);
    chk("sweep_addr", err_addr, 7);
    chk("sweep_src", err_src, 1'b1);
    repeat (2) @(posedge sys_clk);
    #1;

    // Saturation
    repeat (251) host_rd(10'h10, 1'b0, '0, 1'b0);
    chk("sat_254", err_count, 254);
    host_rd(10'h10, 1'b0, '0, 1'b0);
    chk("sat_255", err_count, 255);
    repeat (2) host_rd(10'h10, 1'b0, '0, 1'b0);
    chk("sat_hold", err_count, 255);

    // Reset during HOST_RD
    host_req  = 1'b1;
    host_addr = 10'h10;
    @(posedge sys_clk); #2;
    host_req  = 1'b0;
    host_addr = '0;
    sys_rst   = 1'b1;
    #1;
    chk("mid_rst_host", {host_rvalid, host_rdata, host_err, mem_rd_en, mem_addr}, '0);
    chk("mid_rst_err", {err_count, err_valid, err_addr, err_src, scrub_pass_done}, '0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    chk("post_rst_ready", host_ready, 1'b1);
    rv_seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (host_rvalid || err_count != 0) rv_seen++;
      @(posedge sys_clk); #1;
    end
    chk("post_rst_quiet", rv_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
